// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I front end: widths, reset PC, BTB counter states.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // 2-bit saturating direction counter; bit 1 set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  // Next-PC priority, highest first:
  //   1 jalr      -> jalr_target
  //   2 br        -> br_target
  //   3 br_undo   -> br_undo_target
  //   4 jal       -> jal_target
  //   5 stall     -> pc (hold)
  //   6 BTB taken -> BTB target
  //   7 default   -> pc + 4
  // Redirects sit above stall because a flush must win over a hold.
  localparam int NPC_PRIO_LEVELS = 7;

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module btb_dm
  import cpu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;

  logic            valid_mem [BTB_DEPTH];
  cnt_e            cnt_mem   [BTB_DEPTH];
  logic [TW-1:0]   tag_mem   [BTB_DEPTH];
  logic [XLEN-1:0] tgt_mem   [BTB_DEPTH];

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic [IW-1:0] u_idx;
  logic [TW-1:0] u_tag;
  logic          u_hit;
  logic          unused_lowbits;

  function automatic cnt_e cnt_inc(input cnt_e c);
    return (c == ST) ? ST : cnt_e'(c + 2'd1);
  endfunction

  function automatic cnt_e cnt_dec(input cnt_e c);
    return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
  endfunction

  assign lk_idx = lk_pc[IW+1:2];
  assign lk_tag = lk_pc[XLEN-1:IW+2];
  assign u_idx  = upd_pc[IW+1:2];
  assign u_tag  = upd_pc[XLEN-1:IW+2];
  assign unused_lowbits = ^{lk_pc[1:0], upd_pc[1:0]};

  // Lookup reads pre-edge contents only; an update in the same cycle is not forwarded.
  always_comb begin
    pred_taken  = valid_mem[lk_idx] & (tag_mem[lk_idx] == lk_tag) & cnt_mem[lk_idx][1];
    pred_target = tgt_mem[lk_idx];
    u_hit       = valid_mem[u_idx] & (tag_mem[u_idx] == u_tag);
  end

  // Valid bits and counters: cleared by reset, trained by resolved updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_mem[i] <= 1'b0;
        cnt_mem[i]   <= WNT;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        cnt_mem[u_idx] <= upd_taken ? cnt_inc(cnt_mem[u_idx]) : cnt_dec(cnt_mem[u_idx]);
      end else if (upd_taken) begin
        valid_mem[u_idx] <= 1'b1;
        cnt_mem[u_idx]   <= WT;
      end
    end
  end

  // Tag and target storage; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_mem[u_idx] <= u_tag;
      tgt_mem[u_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/npc_gen_btb.sv
// IF-stage PC register and next-PC priority mux with BTB-driven prediction.
module npc_gen_btb
  import cpu_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            br,
  input  logic [XLEN-1:0] br_target,
  input  logic            br_undo,
  input  logic [XLEN-1:0] br_undo_target,
  input  logic            jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            pred_taken
);

  logic [XLEN-1:0] pred_target;

  btb_dm #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lk_pc       (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  // Next-PC select: EX redirects, then ID jal, then stall hold, then BTB, then sequential.
  always_comb begin
    npc = pc + XLEN'(4);
    if (jalr)            npc = jalr_target;
    else if (br)         npc = br_target;
    else if (br_undo)    npc = br_undo_target;
    else if (jal)        npc = jal_target;
    else if (stall)      npc = pc;
    else if (pred_taken) npc = pred_target;
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= npc;
  end

endmodule
